// File: rtl/da_pkg.sv
// ---------------------------------------------------------------------------
// da_pkg
// Shared types, default sizing and the offset-binary address helper for the
// DA bit-plane address generator.
//
// Contents:
//   DA_K, DA_DATA_WIDTH_X, DA_DATA_WIDTH_B  default vector/operand sizing
//   PLANE_W                                 width of the plane index counter
//   da_gen_state_t                          generator FSM states
//   obc_addr()                              one plane's K bits -> K-1 bit OBC address
// ---------------------------------------------------------------------------
package da_pkg;

   localparam int DA_K            = 8;
   localparam int DA_DATA_WIDTH_X = 8;
   localparam int DA_DATA_WIDTH_B = 8;
   localparam int PLANE_W         = $clog2(DA_DATA_WIDTH_X);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } da_gen_state_t;

   // Offset-binary coding folds the LUT in half: every element is XORed
   // against element 0, and element 0 itself becomes the sign of the lookup.
   function automatic logic [DA_K-2:0] obc_addr(input logic [DA_K-1:0] bits);
      logic [DA_K-2:0] addr;
      addr = '0;
      for (int k = 1; k < DA_K; k++) begin
         addr[k-1] = bits[k] ^ bits[0];
      end
      return addr;
   endfunction

endpackage

// File: rtl/da_shift_bank.sv
// ---------------------------------------------------------------------------
// da_shift_bank
// K parallel right-shift registers holding the latched activations. Bit 0 of
// every lane forms the current bit plane.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (clears every lane)
//   load_i        capture data_i into all lanes (wins over shift_en_i)
//   shift_en_i    shift every lane right by one, zero fill
//   data_i[K]     activation vector to capture
//   plane_bits_o  bit 0 of every lane, lane k on bit k
// ---------------------------------------------------------------------------
module da_shift_bank #(
   parameter int K            = 8,
   parameter int DATA_WIDTH_X = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_i,
   input  logic                           shift_en_i,
   input  logic signed [DATA_WIDTH_X-1:0] data_i [K],
   output logic        [K-1:0]            plane_bits_o
);

   genvar k;
   generate
      for (k = 0; k < K; k++) begin : g_lane
         logic [DATA_WIDTH_X-1:0] sreg_q;

         // One lane: a new vector overwrites the lane, otherwise each emitted
         // plane pushes the next higher bit down into position 0.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sreg_q <= '0;
            end else if (load_i) begin
               sreg_q <= data_i[k];
            end else if (shift_en_i) begin
               sreg_q <= {1'b0, sreg_q[DATA_WIDTH_X-1:1]};
            end
         end

         assign plane_bits_o[k] = sreg_q[0];
      end
   endgenerate

endmodule

// File: rtl/da_bitplane_gen.sv
// ---------------------------------------------------------------------------
// da_bitplane_gen
// Bit-plane address transmitter for the DA LUT. Accepts a vector of K signed
// activations, then emits one offset-binary address plane per cycle, LSB
// plane first, alongside the coefficient registers the LUT is built from.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        activation vector offered on x_in
//   in_ready        vector can be accepted this cycle
//   x_in[K]         activation vector (two's complement)
//   b_load, b_in[K] coefficient load request and coefficient vector
//   B_temp[K]       registered coefficients feeding the LUT
//   addr_array      OBC address of the current plane (K-1 bits)
//   addr_sign       bit of x_0 in the current plane; LUT output is negated
//   gen_done        one strobe per emitted plane
//   plane_idx       bit index j of the current plane
//   plane_msb       current plane is the sign plane (subtract weight)
//   update_pulse    one-cycle pulse the cycle after a vector is accepted
//   out_stall       freezes emission while downstream is not ready
//   busy            generator is emitting a vector
// ---------------------------------------------------------------------------
module da_bitplane_gen
   import da_pkg::*;
#(
   parameter int K            = DA_K,
   parameter int DATA_WIDTH_X = DA_DATA_WIDTH_X,
   parameter int DATA_WIDTH_B = DA_DATA_WIDTH_B
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [DATA_WIDTH_X-1:0]      x_in [K],
   input  logic                                b_load,
   input  logic signed [DATA_WIDTH_B-1:0]      b_in [K],
   output logic signed [DATA_WIDTH_B-1:0]      B_temp [K],
   output logic        [K-2:0]                 addr_array,
   output logic                                addr_sign,
   output logic                                gen_done,
   output logic        [$clog2(DATA_WIDTH_X)-1:0] plane_idx,
   output logic                                plane_msb,
   output logic                                update_pulse,
   input  logic                                out_stall,
   output logic                                busy
);

   localparam int              PW         = $clog2(DATA_WIDTH_X);
   localparam logic [PW-1:0]   LAST_PLANE = PW'(DATA_WIDTH_X - 1);

   da_gen_state_t                  state_q, state_d;
   logic [PW-1:0]                  plane_q, plane_d;
   logic                           updPulse_q;
   logic signed [DATA_WIDTH_B-1:0] coef_q [K];

   logic                           lastPlane;
   logic                           accept;
   logic                           shiftBank;
   logic [K-1:0]                   planeBits;
   logic [K-2:0]                   addrComb;

   // Handshake: always ready when idle, and also on the final plane of a
   // vector so a waiting vector follows with no bubble. A stalled final
   // plane has not been emitted yet, so it cannot hand over.
   always_comb begin
      lastPlane = (state_q == SHIFT) && (plane_q == LAST_PLANE);
      in_ready  = (state_q == IDLE) || (lastPlane && !out_stall);
      accept    = in_valid && in_ready;
      gen_done  = (state_q == SHIFT) && !out_stall;
      shiftBank = gen_done && !accept;
   end

   da_shift_bank #(
      .K            (K),
      .DATA_WIDTH_X (DATA_WIDTH_X)
   ) u_shiftBank (
      .clk          (clk),
      .rst          (rst),
      .load_i       (accept),
      .shift_en_i   (shiftBank),
      .data_i       (x_in),
      .plane_bits_o (planeBits)
   );

   // The package helper is sized for the default K; other sizes build the
   // same XOR-against-lane-0 address with a local loop.
   generate
      if (K == DA_K) begin : g_pkgAddr
         assign addrComb = obc_addr(planeBits);
      end else begin : g_localAddr
         genvar k;
         for (k = 1; k < K; k++) begin : g_bit
            assign addrComb[k-1] = planeBits[k] ^ planeBits[0];
         end
      end
   endgenerate

   // Next-state logic: planes advance only on unstalled cycles; after the
   // last plane either the next vector starts at plane 0 or we go idle.
   always_comb begin
      state_d = state_q;
      plane_d = plane_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               plane_d = '0;
            end
         end
         SHIFT: begin
            if (!out_stall) begin
               if (plane_q == LAST_PLANE) begin
                  state_d = accept ? SHIFT : IDLE;
                  plane_d = '0;
               end else begin
                  plane_d = plane_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            plane_d = '0;
         end
      endcase
   end

   // FSM, plane counter and acceptance pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         plane_q    <= '0;
         updPulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         plane_q    <= plane_d;
         updPulse_q <= accept;
      end
   end

   // Coefficients may only change between vectors, so the LUT contents are
   // constant across every plane of the vector being emitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_q <= '{default: '0};
      end else if (b_load && ((state_q == IDLE) || accept)) begin
         coef_q <= b_in;
      end
   end

   // Plane outputs come straight from the shift bank and counter; both hold
   // while stalled, so these stay stable whenever gen_done is low.
   always_comb begin
      addr_array   = addrComb;
      addr_sign    = planeBits[0];
      plane_idx    = plane_q;
      plane_msb    = lastPlane;
      update_pulse = updPulse_q;
      busy         = (state_q != IDLE);
      B_temp       = coef_q;
   end

endmodule

// File: tb/tb_da_bitplane_gen.sv
// ---------------------------------------------------------------------------
// tb_da_bitplane_gen
// Directed testbench for da_bitplane_gen (K=8, DATA_WIDTH_X=8, DATA_WIDTH_B=8).
// ---------------------------------------------------------------------------
module tb_da_bitplane_gen;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] x_in [8];
   logic              b_load;
   logic signed [7:0] b_in [8];
   logic signed [7:0] B_temp [8];
   logic [6:0]        addr_array;
   logic              addr_sign;
   logic              gen_done;
   logic [2:0]        plane_idx;
   logic              plane_msb;
   logic              update_pulse;
   logic              out_stall;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic signed [7:0] xVec [8];
   logic signed [7:0] bRef [8];
   logic signed [7:0] bAlt [8];

   da_bitplane_gen #(
      .K            (8),
      .DATA_WIDTH_X (8),
      .DATA_WIDTH_B (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .x_in         (x_in),
      .b_load       (b_load),
      .b_in         (b_in),
      .B_temp       (B_temp),
      .addr_array   (addr_array),
      .addr_sign    (addr_sign),
      .gen_done     (gen_done),
      .plane_idx    (plane_idx),
      .plane_msb    (plane_msb),
      .update_pulse (update_pulse),
      .out_stall    (out_stall),
      .busy         (busy)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stops advancing.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference OBC address for plane p of xVec.
   function automatic logic [6:0] expAddr(input int p);
      logic [6:0] a;
      for (int k = 1; k < 8; k++) begin
         a[k-1] = xVec[k][p] ^ xVec[0][p];
      end
      return a;
   endfunction

   // Advance one clock, then drive this cycle's control inputs and let the
   // combinational outputs settle before anything is checked.
   task automatic applyStimulus(input logic v, input logic st, input logic bl);
      @(posedge clk);
      #1;
      in_valid  = v;
      out_stall = st;
      b_load    = bl;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   initial begin
      int p;
      int upCount;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_stall = 1'b0;
      b_load    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         x_in[k] = '0;
         b_in[k] = '0;
      end
      bRef = '{-8'sd128, -8'sd1, 8'sd0, 8'sd1, 8'sd127, -8'sd64, 8'sd5, -8'sd7};
      bAlt = '{8'sd11, 8'sd22, 8'sd33, 8'sd44, 8'sd55, 8'sd66, 8'sd77, 8'sd88};

      // Reset values.
      #3;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_gen_done", gen_done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_update", update_pulse, 0);
      checkOutput("rst_addr", addr_array, 0);
      checkOutput("rst_btemp0", B_temp[0], 0);
      #9;
      rst = 1'b0;

      // Coefficient load while idle.
      b_in = bRef;
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      for (int k = 0; k < 8; k++) checkOutput($sformatf("bload_idle_%0d", k), B_temp[k], bRef[k]);

      // x_k = k, no stall; coefficient loads during emission must be ignored.
      for (int k = 0; k < 8; k++) xVec[k] = 8'(k);
      x_in = xVec;
      applyStimulus(1, 0, 0);
      checkOutput("seq_accept_ready", in_ready, 1);
      b_in = bAlt;
      applyStimulus(0, 0, 1);
      checkOutput("seq_p0_done", gen_done, 1);
      checkOutput("seq_p0_update", update_pulse, 1);
      checkOutput("seq_p0_idx", plane_idx, 0);
      checkOutput("seq_p0_addr", addr_array, 7'b1010101);
      checkOutput("seq_p0_sign", addr_sign, 0);
      checkOutput("seq_p0_msb", plane_msb, 0);
      for (p = 1; p < 8; p++) begin
         applyStimulus(0, 0, (p < 7) ? 1'b1 : 1'b0);
         checkOutput($sformatf("seq_p%0d_done", p), gen_done, 1);
         checkOutput($sformatf("seq_p%0d_idx", p), plane_idx, p);
         checkOutput($sformatf("seq_p%0d_addr", p), addr_array, expAddr(p));
         if (p == 1) checkOutput("seq_p1_update", update_pulse, 0);
      end
      checkOutput("seq_p7_addr_zero", addr_array, 0);
      checkOutput("seq_p7_msb", plane_msb, 1);
      checkOutput("seq_p7_ready", in_ready, 1);
      applyStimulus(0, 0, 0);
      checkOutput("seq_end_done", gen_done, 0);
      checkOutput("seq_end_busy", busy, 0);
      for (int k = 0; k < 8; k++) checkOutput($sformatf("bload_shift_%0d", k), B_temp[k], bRef[k]);

      // x_0 = -1, all others 0: every plane negated with a full address.
      for (int k = 0; k < 8; k++) xVec[k] = '0;
      xVec[0] = -8'sd1;
      x_in = xVec;
      applyStimulus(1, 0, 0);
      for (p = 0; p < 8; p++) begin
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("neg_p%0d_done", p), gen_done, 1);
         checkOutput($sformatf("neg_p%0d_sign", p), addr_sign, 1);
         checkOutput($sformatf("neg_p%0d_addr", p), addr_array, 7'h7F);
      end
      applyStimulus(0, 0, 0);
      checkOutput("neg_end_busy", busy, 0);

      // Back-to-back vectors with in_valid held high.
      for (int k = 0; k < 8; k++) xVec[k] = 8'(k);
      x_in = xVec;
      applyStimulus(1, 0, 0);
      upCount = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus((i < 8) ? 1'b1 : 1'b0, 0, 0);
         checkOutput($sformatf("b2b_%0d_done", i), gen_done, 1);
         checkOutput($sformatf("b2b_%0d_idx", i), plane_idx, i % 8);
         if (update_pulse) upCount++;
         if (i == 8) checkOutput("b2b_second_p0_addr", addr_array, 7'b1010101);
      end
      checkOutput("b2b_update_count", upCount, 2);
      applyStimulus(0, 0, 0);
      checkOutput("b2b_end_done", gen_done, 0);

      // Three stall cycles at plane 3.
      applyStimulus(1, 0, 0);
      p = 0;
      for (int c = 0; c < 11; c++) begin
         applyStimulus(0, (c >= 3 && c <= 5) ? 1'b1 : 1'b0, 0);
         checkOutput($sformatf("stall_c%0d_done", c), gen_done, (c >= 3 && c <= 5) ? 0 : 1);
         checkOutput($sformatf("stall_c%0d_idx", c), plane_idx, p);
         if (!(c >= 3 && c <= 5)) begin
            checkOutput($sformatf("stall_c%0d_addr", c), addr_array, expAddr(p));
            p++;
         end
      end
      checkOutput("stall_plane_count", p, 8);
      applyStimulus(0, 0, 0);
      checkOutput("stall_end_busy", busy, 0);

      // Asynchronous reset at plane 4.
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
      checkOutput("rst_mid_idx_before", plane_idx, 4);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_done", gen_done, 0);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_idx", plane_idx, 0);
      checkOutput("rst_mid_addr", addr_array, 0);
      checkOutput("rst_mid_btemp0", B_temp[0], 0);
      checkOutput("rst_mid_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) xVec[k] = '0;
      xVec[0] = -8'sd1;
      x_in = xVec;
      applyStimulus(1, 0, 0);
      checkOutput("post_rst_ready", in_ready, 1);
      applyStimulus(0, 0, 0);
      checkOutput("post_rst_done", gen_done, 1);
      checkOutput("post_rst_idx", plane_idx, 0);
      checkOutput("post_rst_sign", addr_sign, 1);
      checkOutput("post_rst_addr", addr_array, 7'h7F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
